shift_counter: RTL and testbench
================================

Name: shift_counter

Overview:
Parametrised twisted-ring (Johnson) / ring counter with enable, direction control, synchronous parallel load, illegal-state self-correction and terminal-count flag. It is the generalised replacement for the fixed 4-bit Johnson counter. Used as a glitch-free one-hot/thermometer sequencer and phase generator. Bit 0 is the first stage of the chain.

Parameters:
WIDTH, 4, number of register stages (legal range 2..32)
IDXW, $clog2(2*WIDTH), width of phase index output (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (rst=0 resets)
en  input  1  advance one step this cycle
mode  input  1  0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
dir  input  1  0 = shift toward MSB, 1 = shift toward bit 0
load  input  1  synchronous parallel load, priority over en
load_val  input  WIDTH  value for load
q  output  WIDTH  counter state, registered
idx  output  IDXW  phase index of q, combinational from q and mode
tc  output  1  terminal-count pulse, registered
err  output  1  illegal-state correction pulse, registered

Behaviour:
- Reset (rst=0, async): q=0, tc=0, err=0. Release is synchronous to clk by the system.
- Priority per rising edge: load > en > hold. With load=0 and en=0: q holds, tc=0, err=0.
- tc and err are single-cycle pulses, cleared on every edge that does not set them.
- Johnson step, dir=0: q <= {q[W-2:0], ~q[W-1]}. Sequence from 0 at W=4: 0000,0001,0011,0111,1111,1110,1100,1000,0000.
- Johnson step, dir=1: q <= {~q[0], q[W-1:1]}. This is the exact reverse sequence.
- Ring step, dir=0: q <= {q[W-2:0], q[W-1]}.
- Ring step, dir=1: q <= {q[0], q[W-1:1]}.
- Johnson legal state: at most one i in 0..W-2 with q[i]!=q[i+1].
- Ring legal state: exactly one bit set.
- Ring seed: q=0 in ring mode is a seed state, not an error. On en it loads 1 (bit 0), with err=0 and tc=0.
- Illegal-state correction: on an en edge with q illegal for the current mode, q <= canonical start (Johnson 0, ring 1) and err=1. There is no step and tc=0 on that edge.
- A mode change mid-count is not special-cased. Any resulting illegal state is corrected on the next en edge.
- Load: a legal load_val (for the current mode) gives q <= load_val. An illegal load_val gives q <= canonical start and err=1. Load never sets tc.
- Ring seed on load: ring-mode load_val=0 is treated as illegal and gives q=1, err=1.
- idx, Johnson: q[0]=1 gives popcount(q). q=0 gives 0. Otherwise idx = 2W - popcount(q).
- idx, ring: bit position of the set bit, or 0 if q=0.
- idx for an illegal q is don't-care.
- tc: set on an en step (not correction or seed) whose new state has idx 0 when dir=0, or idx max when dir=1.
  - Johnson max = 2W-1.
  - Ring max = W-1.
- Direction reversal takes effect on the same edge. There is no extra state.
- Reset mid-operation: immediate async clear of q, tc and err, regardless of load or en.

Test Plan:
1. W=4, mode=0, dir=0, en=1 for 9 cycles after reset.
   - q = 0001,0011,0111,1111,1110,1100,1000,0000,0001.
   - idx = 1..7,0,1.
   - tc=1 only on the 0000 cycle.
2. W=4, mode=0, from 0000 with dir=1, en=1.
   - q = 1000,1100,1110,1111.
   - tc=1 on the first step (idx 7).
   - Set dir=0 at 1111: next q = 1110.
3. W=4, mode=1, en=1 from reset.
   - q = 0001 (seed, err=0), then 0010,0100,1000,0001.
   - tc=1 on the return to 0001.
   - With dir=1 from 0001, next q = 1000 and tc=1.
4. Load checks.
   - load=1, load_val=0101, mode=0: q=0000, err=1 for one cycle.
   - load_val=0111: q=0111, err=0.
   - load and en both 1: load wins.
5. Illegal state on en.
   - mode=0 at q=0011, switch to mode=1 and en=1: q=0001, err=1, tc=0.
   - With en=0, an illegal q holds and err=0.
6. Async reset mid-count: drive rst=0 between clock edges at q=0111.
   - q=0000, tc=0, err=0 immediately, with no clock edge needed.
   - Counting resumes from 0001 on the first en edge after release.

Source files
------------

// File: rtl/shift_counter.sv
// Johnson / ring sequencer with load, direction control, illegal-state self-correction
// and registered terminal-count and error pulses. Bit 0 is the first stage of the chain.
module shift_counter #(
    parameter  int WIDTH = 4,
    localparam int IDXW  = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             tc,
    output logic             err
);

    localparam logic [IDXW-1:0] JOHNSON_MAX = IDXW'(2*WIDTH - 1);
    localparam logic [IDXW-1:0] RING_MAX    = IDXW'(WIDTH - 1);

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Johnson states have at most one boundary between a run of ones and a run of zeros.
    function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic m);
        int edges;
        edges = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (v[i] != v[i+1]) edges++;
        end
        if (m) return (popcount(v) == 1);
        return (edges <= 1);
    endfunction

    function automatic logic [IDXW-1:0] idx_of(input logic [WIDTH-1:0] v, input logic m);
        int r;
        r = 0;
        if (m) begin
            for (int i = WIDTH-1; i >= 0; i--) begin
                if (v[i]) r = i;
            end
        end else if (v[0]) begin
            r = popcount(v);
        end else if (v != '0) begin
            r = 2*WIDTH - popcount(v);
        end
        return IDXW'(r);
    endfunction

    function automatic logic [WIDTH-1:0] step_of(input logic [WIDTH-1:0] v,
                                                 input logic m, input logic d);
        logic feed_lo;
        logic feed_hi;
        feed_lo = m ? v[WIDTH-1] : ~v[WIDTH-1];
        feed_hi = m ? v[0]       : ~v[0];
        if (d) return {feed_hi, v[WIDTH-1:1]};
        return {v[WIDTH-2:0], feed_lo};
    endfunction

    logic [WIDTH-1:0] q_d, q_q;
    logic             tc_d, tc_q;
    logic             err_d, err_q;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] next_val;
    logic [IDXW-1:0]  next_idx;

    always_comb begin
        start_val = mode ? WIDTH'(1) : '0;
        next_val  = step_of(q_q, mode, dir);
        next_idx  = idx_of(next_val, mode);
        q_d       = q_q;
        tc_d      = 1'b0;
        err_d     = 1'b0;
        if (load) begin
            if (is_legal(load_val, mode)) begin
                q_d = load_val;
            end else begin
                q_d   = start_val;
                err_d = 1'b1;
            end
        end else if (en) begin
            // All-zero is the ring seed, not an error.
            if (mode && q_q == '0) begin
                q_d = start_val;
            end else if (!is_legal(q_q, mode)) begin
                q_d   = start_val;
                err_d = 1'b1;
            end else begin
                q_d  = next_val;
                tc_d = dir ? (next_idx == (mode ? RING_MAX : JOHNSON_MAX))
                           : (next_idx == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign q   = q_q;
    assign tc  = tc_q;
    assign err = err_q;
    assign idx = idx_of(q_q, mode);

endmodule

// File: tb/tb_shift_counter.sv
// Bench for shift_counter: phase-based reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_shift_counter;
    localparam int W    = 4;
    localparam int IDXW = $clog2(2*W);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
    logic [W-1:0]   load_val = '0;
    logic [W-1:0]   q;
    logic [IDXW-1:0] idx;
    logic           tc, err;

    int total = 0;
    int bad   = 0;

    shift_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .load(load),
        .load_val(load_val), .q(q), .idx(idx), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Johnson state for phase k: k ones filling from bit 0, then zeros filling from bit 0.
    function automatic int jq(input int k);
        int full;
        full = (1 << W) - 1;
        if (k <= W) return (1 << k) - 1;
        return full & ~((1 << (k - W)) - 1);
    endfunction

    function automatic int jphase(input int v);
        for (int k = 0; k < 2*W; k++) if (jq(k) == v) return k;
        return -1;
    endfunction

    function automatic int rphase(input int v);
        for (int k = 0; k < W; k++) if ((1 << k) == v) return k;
        return -1;
    endfunction

    int mq = 0, mtc = 0, merr = 0;

    always @(posedge clk or negedge rst) begin
        int ph, n, nk;
        if (!rst) begin
            mq = 0; mtc = 0; merr = 0;
        end else begin
            mtc = 0; merr = 0;
            n = mode ? W : 2*W;
            if (load) begin
                ph = mode ? rphase(int'(load_val)) : jphase(int'(load_val));
                if (ph >= 0) mq = int'(load_val);
                else begin mq = mode ? 1 : 0; merr = 1; end
            end else if (en) begin
                ph = mode ? rphase(mq) : jphase(mq);
                if (mode && mq == 0) mq = 1;
                else if (ph < 0) begin mq = mode ? 1 : 0; merr = 1; end
                else begin
                    nk  = dir ? (ph + n - 1) % n : (ph + 1) % n;
                    mq  = mode ? (1 << nk) : jq(nk);
                    mtc = dir ? int'(nk == n - 1) : int'(nk == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        int ph;
        if (rst) begin
            chk("model q", int'(q), mq);
            chk("model tc", int'(tc), mtc);
            chk("model err", int'(err), merr);
            ph = mode ? ((mq == 0) ? 0 : rphase(mq)) : jphase(mq);
            if (ph >= 0) chk("model idx", int'(idx), ph);
        end
    end

    task automatic cyc(input string nm, input logic e, input logic l, input logic m,
                       input logic d, input int lv, input int eq, input int etc, input int eerr);
        en = e; load = l; mode = m; dir = d; load_val = W'(lv);
        @(posedge clk);
        #1;
        chk({nm, " q"}, int'(q), eq);
        chk({nm, " tc"}, int'(tc), etc);
        chk({nm, " err"}, int'(err), eerr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int t1_q[9]   = '{1, 3, 7, 15, 14, 12, 8, 0, 1};
    int t1_idx[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset q", int'(q), 0);
        chk("reset tc", int'(tc), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;

        // Johnson count up through a full lap
        for (int i = 0; i < 9; i++) begin
            cyc("t1", 1, 0, 0, 0, 0, t1_q[i], (t1_q[i] == 0) ? 1 : 0, 0);
            chk("t1 idx", int'(idx), t1_idx[i]);
        end

        // Johnson count down, then reverse at 1111
        cyc("t2 load0", 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("t2 d1", 1, 0, 0, 1, 0, 8, 1, 0);
        chk("t2 idx7", int'(idx), 7);
        cyc("t2 d2", 1, 0, 0, 1, 0, 12, 0, 0);
        cyc("t2 d3", 1, 0, 0, 1, 0, 14, 0, 0);
        cyc("t2 d4", 1, 0, 0, 1, 0, 15, 0, 0);
        cyc("t2 rev", 1, 0, 0, 0, 0, 14, 0, 0);

        // Ring from reset: seed, rotate, wrap, reverse
        do_reset();
        cyc("t3 seed", 1, 0, 1, 0, 0, 1, 0, 0);
        cyc("t3 r1", 1, 0, 1, 0, 0, 2, 0, 0);
        cyc("t3 r2", 1, 0, 1, 0, 0, 4, 0, 0);
        cyc("t3 r3", 1, 0, 1, 0, 0, 8, 0, 0);
        chk("t3 idx3", int'(idx), 3);
        cyc("t3 wrap", 1, 0, 1, 0, 0, 1, 1, 0);
        cyc("t3 rev", 1, 0, 1, 1, 0, 8, 1, 0);

        // Loads
        cyc("t4 bad", 0, 1, 0, 0, 5, 0, 0, 1);
        cyc("t4 hold", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4 good", 0, 1, 0, 0, 7, 7, 0, 0);
        cyc("t4 prio", 1, 1, 0, 0, 3, 3, 0, 0);

        // Illegal state after a mode change
        cyc("t5 hold", 0, 0, 1, 0, 0, 3, 0, 0);
        cyc("t5 fix", 1, 0, 1, 0, 0, 1, 0, 1);
        cyc("t5 ld0", 0, 1, 1, 0, 0, 1, 0, 1);
        cyc("t5 ld4", 0, 1, 1, 0, 4, 4, 0, 0);
        chk("t5 idx2", int'(idx), 2);

        // Async reset between edges
        do_reset();
        cyc("t6 a", 1, 0, 0, 0, 0, 1, 0, 0);
        cyc("t6 b", 1, 0, 0, 0, 0, 3, 0, 0);
        cyc("t6 c", 1, 0, 0, 0, 0, 7, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6 async q", int'(q), 0);
        chk("t6 async tc", int'(tc), 0);
        chk("t6 async err", int'(err), 0);
        @(negedge clk);
        rst = 1'b1;
        cyc("t6 resume", 1, 0, 0, 0, 0, 1, 0, 0);

        en = 1'b0;
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
